// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller transaction port between several requesters.
// Latches the winner's fields, holds the controller request until ack, and aborts on a watchdog.
`timescale 1ns/1ps

module i2c_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [REQUESTERS-1:0]   req_valid_i,
  input  logic [REQUESTERS-1:0]   req_wr_i,
  input  logic [6*REQUESTERS-1:0] req_addr_i,
  input  logic [3*REQUESTERS-1:0] req_bytes_i,
  input  logic [8*REQUESTERS-1:0] req_wdata_i,
  output logic [REQUESTERS-1:0]   req_ack_o,
  output logic [REQUESTERS-1:0]   req_err_o,
  output logic [7:0]              req_rdata_o,
  output logic [REQUESTERS-1:0]   grant_o,
  output logic                    busy_o,
  output logic                    ctrl_req_o,
  output logic                    ctrl_wr_o,
  output logic [5:0]              ctrl_addr_o,
  output logic [2:0]              ctrl_bytes_o,
  inout  wire  [7:0]              ctrl_data_io,
  input  logic                    ctrl_ack_i
);

  localparam int unsigned IdxW = $clog2(REQUESTERS);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [IdxW-1:0]       LastRst = IdxW'(REQUESTERS - 1);
  localparam logic [CntW-1:0]       WdLast  = CntW'(TIMEOUT - 1);
  localparam logic [REQUESTERS-1:0] OneHot0 = REQUESTERS'(1);

  typedef enum logic [1:0] {StIdle, StGrant, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [CntW-1:0]       wd_q, wd_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic [5:0]            addr_q, addr_d;
  logic [2:0]            bytes_q, bytes_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  ack_pend_q, ack_pend_d;
  logic                  err_pend_q, err_pend_d;

  logic                  pick_found;
  logic [IdxW-1:0]       pick_idx;
  logic [IdxW-1:0]       cand;

  // Search upward from last+1 (mod N); the first pending requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand = IdxW'((32'(last_q) + k) % REQUESTERS);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    wd_d       = wd_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_pend_d = ack_pend_q;
    err_pend_d = err_pend_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d    = StGrant;
          last_d     = pick_idx;
          grant_d    = OneHot0 << pick_idx;
          wr_d       = req_wr_i[pick_idx];
          addr_d     = req_addr_i[6*pick_idx +: 6];
          bytes_d    = req_bytes_i[3*pick_idx +: 3];
          wdata_d    = req_wdata_i[8*pick_idx +: 8];
          wd_d       = '0;
          ack_pend_d = 1'b0;
          err_pend_d = 1'b0;
        end
      end
      StGrant: begin
        // A completion on the expiry edge takes priority over the abort.
        if (ctrl_ack_i) begin
          rdata_d    = ctrl_data_io;
          ack_pend_d = 1'b1;
          state_d    = StDone;
        end else if (wd_q == WdLast) begin
          err_pend_d = 1'b1;
          state_d    = StDone;
        end else begin
          wd_d = wd_q + CntW'(1);
        end
      end
      StDone: begin
        grant_d    = '0;
        ack_pend_d = 1'b0;
        err_pend_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      last_q     <= LastRst;
      wd_q       <= '0;
      grant_q    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      bytes_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_pend_q <= ack_pend_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign ctrl_req_o   = (state_q == StGrant);
  assign ctrl_wr_o    = wr_q;
  assign ctrl_addr_o  = addr_q;
  assign ctrl_bytes_o = bytes_q;
  assign grant_o      = grant_q;
  assign req_rdata_o  = rdata_q;
  assign req_ack_o    = (state_q == StDone && ack_pend_q) ? grant_q : '0;
  assign req_err_o    = (state_q == StDone && err_pend_q) ? grant_q : '0;
  assign ctrl_data_io = (ctrl_req_o && wr_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: a default-timeout instance for arbitration and data paths,
// and a TIMEOUT=16 instance for watchdog behaviour.
`timescale 1ns/1ps

module tb_i2c_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid, req_wr;
  logic [23:0] req_addr;
  logic [11:0] req_bytes;
  logic [31:0] req_wdata;
  logic        ctrl_ack;
  logic        tb_en;
  logic [7:0]  tb_data;
  wire  [7:0]  data_a, data_b;

  // Controller-side bus driver; when disabled the net belongs to the arbiter.
  assign data_a = tb_en ? tb_data : 8'hzz;
  assign data_b = tb_en ? tb_data : 8'hzz;

  logic [3:0] ack_a, err_a, grant_a, ack_b, err_b, grant_b;
  logic [7:0] rdata_a, rdata_b;
  logic       busy_a, creq_a, cwr_a, busy_b, creq_b, cwr_b;
  logic [5:0] caddr_a, caddr_b;
  logic [2:0] cbytes_a, cbytes_b;

  i2c_arbiter #(.REQUESTERS(4), .TIMEOUT(65535)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_bytes_i(req_bytes), .req_wdata_i(req_wdata),
    .req_ack_o(ack_a), .req_err_o(err_a), .req_rdata_o(rdata_a), .grant_o(grant_a),
    .busy_o(busy_a), .ctrl_req_o(creq_a), .ctrl_wr_o(cwr_a), .ctrl_addr_o(caddr_a),
    .ctrl_bytes_o(cbytes_a), .ctrl_data_io(data_a), .ctrl_ack_i(ctrl_ack)
  );

  i2c_arbiter #(.REQUESTERS(4), .TIMEOUT(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_bytes_i(req_bytes), .req_wdata_i(req_wdata),
    .req_ack_o(ack_b), .req_err_o(err_b), .req_rdata_o(rdata_b), .grant_o(grant_b),
    .busy_o(busy_b), .ctrl_req_o(creq_b), .ctrl_wr_o(cwr_b), .ctrl_addr_o(caddr_b),
    .ctrl_bytes_o(cbytes_b), .ctrl_data_io(data_b), .ctrl_ack_i(ctrl_ack)
  );

  typedef struct {
    logic [3:0] add;
    logic [3:0] exp_grant;
    logic [5:0] exp_addr;
    logic [2:0] exp_bytes;
  } vec_t;

  vec_t vecs[11];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    ctrl_ack  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Serve one transaction on instance A: wait for grant, ack two cycles in, drop the request.
  task automatic serve(input vec_t v);
    int         waited;
    logic [3:0] g;
    req_valid = req_valid | v.add;
    waited = 0;
    g      = 4'b0000;
    while (g == 4'b0000 && waited < 8) begin
      @(negedge clk);
      waited++;
      g = grant_a;
    end
    check("rr_grant", 32'(g), 32'(v.exp_grant));
    check("rr_latency", 32'(waited), 1);
    check("rr_addr", 32'(caddr_a), 32'(v.exp_addr));
    check("rr_bytes", 32'(cbytes_a), 32'(v.exp_bytes));
    check("rr_ctrl_req", 32'(creq_a), 1);
    @(negedge clk);
    ctrl_ack = 1'b1;
    @(negedge clk);
    ctrl_ack = 1'b0;
    check("rr_ack", 32'(ack_a), 32'(v.exp_grant));
    req_valid = req_valid & ~v.exp_grant;
    @(negedge clk);
    check("rr_idle_busy", 32'(busy_a), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int ngrant, nack, nerr, nreq, c_err, c_next;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_wr    = 4'b0000;
    req_addr  = {6'h2A, 6'h15, 6'h11, 6'h08};
    req_bytes = {3'd7, 3'd3, 3'd2, 3'd1};
    req_wdata = {8'h81, 8'h77, 8'h5E, 8'h3C};
    ctrl_ack  = 1'b0;
    tb_en     = 1'b1;
    tb_data   = 8'h5A;

    vecs[0]  = '{add: 4'b1111, exp_grant: 4'b0001, exp_addr: 6'h08, exp_bytes: 3'd1};
    vecs[1]  = '{add: 4'b0000, exp_grant: 4'b0010, exp_addr: 6'h11, exp_bytes: 3'd2};
    vecs[2]  = '{add: 4'b0000, exp_grant: 4'b0100, exp_addr: 6'h15, exp_bytes: 3'd3};
    vecs[3]  = '{add: 4'b0000, exp_grant: 4'b1000, exp_addr: 6'h2A, exp_bytes: 3'd7};
    vecs[4]  = '{add: 4'b0010, exp_grant: 4'b0010, exp_addr: 6'h11, exp_bytes: 3'd2};
    vecs[5]  = '{add: 4'b1101, exp_grant: 4'b0100, exp_addr: 6'h15, exp_bytes: 3'd3};
    vecs[6]  = '{add: 4'b0000, exp_grant: 4'b1000, exp_addr: 6'h2A, exp_bytes: 3'd7};
    vecs[7]  = '{add: 4'b0000, exp_grant: 4'b0001, exp_addr: 6'h08, exp_bytes: 3'd1};
    vecs[8]  = '{add: 4'b0010, exp_grant: 4'b0010, exp_addr: 6'h11, exp_bytes: 3'd2};
    vecs[9]  = '{add: 4'b1001, exp_grant: 4'b1000, exp_addr: 6'h2A, exp_bytes: 3'd7};
    vecs[10] = '{add: 4'b0000, exp_grant: 4'b0001, exp_addr: 6'h08, exp_bytes: 3'd1};

    // Reset state
    @(negedge clk);
    check("rst_grant", 32'(grant_a), 0);
    check("rst_ack_err", 32'({ack_a, err_a}), 0);
    check("rst_rdata", 32'(rdata_a), 0);
    check("rst_busy_req_wr", 32'({busy_a, creq_a, cwr_a}), 0);
    check("rst_addr_bytes", 32'({caddr_a, cbytes_a}), 0);
    check("rst_data_z", 32'(data_a), 'h5A);
    rst_n = 1'b1;

    // Single read: requester 2, controller acks after 40 cycles with 0xA5
    @(negedge clk);
    req_valid = 4'b0100;
    ngrant = 0; nack = 0; nerr = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (grant_a == 4'b0100) ngrant++;
      if (c == 0) begin
        check("sr_addr", 32'(caddr_a), 'h15);
        check("sr_bytes", 32'(cbytes_a), 3);
        check("sr_wr_req_busy", 32'({cwr_a, creq_a, busy_a}), 'b011);
        check("sr_data_z", 32'(data_a), 'h5A);
      end
      if (c == 40) check("sr_done_req", 32'(creq_a), 0);
      if (ack_a != 4'b0000) begin
        nack++;
        check("sr_ack_vec", 32'(ack_a), 'b0100);
        check("sr_rdata", 32'(rdata_a), 'hA5);
        req_valid = 4'b0000;
      end
      if (err_a != 4'b0000) nerr++;
      ctrl_ack = (c == 39);
      tb_data  = (c == 39) ? 8'hA5 : 8'h5A;
    end
    check("sr_grant_cycles", 32'(ngrant), 41);
    check("sr_ack_count", 32'(nack), 1);
    check("sr_err_count", 32'(nerr), 0);

    // Round-robin table
    do_reset();
    foreach (vecs[i]) serve(vecs[i]);

    // Write drive with mid-grant wdata change
    do_reset();
    req_wr  = 4'b0001;
    tb_data = 8'h00;
    @(negedge clk);
    check("wr_idle_bus", 32'(data_a), 0);
    req_valid = 4'b0001;
    tb_en     = 1'b0;
    @(negedge clk);
    check("wr_req_wr", 32'({creq_a, cwr_a}), 'b11);
    check("wr_data", 32'(data_a), 'h3C);
    req_wdata[7:0] = 8'hFF;
    @(negedge clk);
    check("wr_data_hold", 32'(data_a), 'h3C);
    ctrl_ack = 1'b1;
    @(negedge clk);
    ctrl_ack = 1'b0;
    tb_en    = 1'b1;
    #1;
    check("wr_ack", 32'(ack_a), 'b0001);
    check("wr_done_bus", 32'(data_a), 0);
    req_valid      = 4'b0000;
    req_wr         = 4'b0000;
    req_wdata[7:0] = 8'h3C;
    tb_data        = 8'h5A;

    // Timeout on instance B (TIMEOUT=16), requester 1 waiting behind
    do_reset();
    req_valid = 4'b0011;
    nreq = 0; nerr = 0; nack = 0; c_err = -1; c_next = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c_err < 0 && creq_b) nreq++;
      if (err_b != 4'b0000) begin
        nerr++;
        if (c_err < 0) begin
          c_err = c;
          check("to_err_vec", 32'(err_b), 'b0001);
          req_valid[0] = 1'b0;
        end
      end
      if (ack_b != 4'b0000) nack++;
      if (c_err >= 0 && c_next < 0 && grant_b == 4'b0010) c_next = c;
    end
    check("to_req_cycles", 32'(nreq), 16);
    check("to_err_cycle", 32'(c_err), 16);
    check("to_err_count", 32'(nerr), 1);
    check("to_ack_count", 32'(nack), 0);
    check("to_next_gap", 32'(c_next - c_err), 2);

    // Ack arriving on the watchdog-expiry edge
    do_reset();
    req_valid = 4'b0001;
    nack = 0; nerr = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (ack_b != 4'b0000) begin
        nack++;
        check("col_rdata", 32'(rdata_b), 'hC3);
        req_valid = 4'b0000;
      end
      if (err_b != 4'b0000) nerr++;
      ctrl_ack = (c == 15);
      tb_data  = (c == 15) ? 8'hC3 : 8'h5A;
    end
    check("col_ack_count", 32'(nack), 1);
    check("col_err_count", 32'(nerr), 0);

    // Reset during a write grant
    do_reset();
    tb_data   = 8'h00;
    req_wr    = 4'b0100;
    req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("mr_pre_grant", 32'(grant_a), 'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_grant_busy", 32'({creq_a, busy_a, grant_a}), 0);
    check("mr_fields", 32'({cwr_a, caddr_a, cbytes_a}), 0);
    check("mr_data_z", 32'(data_a), 0);
    req_valid = 4'b1111;
    ctrl_ack  = 1'b1;
    nack = 0; nerr = 0;
    @(negedge clk);
    if (ack_a != 4'b0000) nack++;
    if (err_a != 4'b0000) nerr++;
    ctrl_ack = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    if (ack_a != 4'b0000) nack++;
    if (err_a != 4'b0000) nerr++;
    check("mr_first_grant", 32'(grant_a), 'b0001);
    check("mr_no_ack_err", 32'(nack + nerr), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Shares the single `i2c_controller` transaction port between several requesters, such as the CPU bus bridge and on-board device drivers. It selects one pending request by round-robin and latches that request's fields. It then drives the controller's request interface and holds it until the controller acknowledges, and returns the acknowledge and read data to the winning requester. A watchdog aborts transactions the controller never acknowledges.

## Interface
- `REQUESTERS`, 4: number of requester ports, N (2..8).
- `TIMEOUT`, 65535: maximum number of cycles spent in GRANT before the transaction is aborted (≥1). The counter width is `$clog2(TIMEOUT+1)`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  per-requester request; held until `req_ack`/`req_err`.
- `req_wr`  in  N  1 = write, 0 = read.
- `req_addr`  in  6·N  device address; requester i occupies bits [6i+5:6i].
- `req_bytes`  in  3·N  byte count, packed as above.
- `req_wdata`  in  8·N  write data, packed as above.
- `req_ack`  out  N  one-cycle completion pulse to the granted requester.
- `req_err`  out  N  one-cycle timeout pulse to the granted requester.
- `req_rdata`  out  8  read data; valid while `req_ack` is high.
- `grant`  out  N  one-hot current owner; all zero when idle.
- `busy`  out  1  high in any state other than IDLE.
- `ctrl_req`  out  1  request to the controller (level).
- `ctrl_wr`, `ctrl_addr`[6], `ctrl_bytes`[3]  out  latched transaction fields.
- `ctrl_data`  inout  8  driven with latched wdata only when `ctrl_req` and `ctrl_wr` are both high; otherwise 8'bz.
- `ctrl_ack`  in  1  controller completion.

## Operation
The arbiter is a three-state FSM: IDLE → GRANT → DONE → IDLE.

- **IDLE**
  - If any `req_valid` bit is high, pick the first set bit by searching upward from `last+1` modulo N. `last` is the index of the previous winner.
  - Latch that requester's wr/addr/bytes/wdata, set `grant`, update `last`, clear the watchdog and go to GRANT.
  - If no bit is set, stay in IDLE.
- **GRANT**
  - `ctrl_req`=1 and the fields are stable for the whole state.
  - If `ctrl_ack`=1: capture `ctrl_data` into `req_rdata` (captured for writes too; don't-care), set `ack_pend` and go to DONE.
  - Otherwise, if the watchdog equals TIMEOUT−1: set `err_pend` and go to DONE.
  - Otherwise increment the watchdog.
- **DONE**
  - `ctrl_req`=0.
  - `req_ack[owner]`=`ack_pend` or `req_err[owner]`=`err_pend`; exactly one of the two is high.
  - Clear `grant`, then go to IDLE.
- **Field latching**: fields are latched at grant. Requester inputs that change afterwards are ignored.
- **Early deassert**: if `req_valid` is deasserted during GRANT, the transaction still completes and is still acknowledged.
- **Requester rule**: a requester deasserts `req_valid` on the edge where it samples `req_ack` or `req_err`. This guarantees the request is not re-granted.
- **Fairness**: a requester that stays pending is granted within N transactions.
- **Late `ctrl_ack`**: a `ctrl_ack` arriving in IDLE or DONE is ignored.
- **Reset** (any state, asynchronous): state=IDLE, `last`=N−1 (requester 0 wins first), watchdog=0.
  - All outputs return to 0: `grant`, `req_ack`, `req_err`, `req_rdata`, `busy`, `ctrl_req`, `ctrl_wr`, `ctrl_addr`, `ctrl_bytes`.
  - `ctrl_data` goes to Z.
  - An aborted transaction produces no ack or err.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `req_*` to `ctrl_*`.
- **Grant latency**: `req_valid` sampled high at edge k (FSM in IDLE) → `grant` and `ctrl_req` high after edge k.
- **Completion latency**: `ctrl_ack` sampled high at edge m → `ctrl_req` low and `req_ack` high for one cycle after edge m; `grant` and `busy` go low after edge m+1.
- **Back-to-back**: the minimum gap from `ctrl_ack` to the next `ctrl_req` is 2 cycles (DONE, then IDLE).
- **Timeout**: `ctrl_req` is high for exactly TIMEOUT cycles, then `req_err` pulses in the following cycle.
- **Simultaneous events**: `ctrl_ack` wins over timeout when both occur on the same edge.

## Test plan
- **Single read**: reset, then requester 2 reads addr 0x15, 3 bytes; controller model acks after 40 cycles with data 0xA5.
  - Required: `grant`=0100 for 41 cycles, `ctrl_addr`=0x15, `ctrl_bytes`=3, `ctrl_data`=Z, one `req_ack[2]` pulse with `req_rdata`=0xA5.
- **Round-robin**: all 4 requesters pending continuously, each deasserting on its ack.
  - Required: grant order 0,1,2,3; then requester 1 re-asserts and is granted next. No requester is granted twice in a row while others are pending.
- **Write drive**: requester 0 writes 0x3C.
  - Required: `ctrl_data`=0x3C while `ctrl_req`=1 and Z otherwise. Changing `req_wdata[0]` mid-GRANT does not alter `ctrl_data`.
- **Timeout**: TIMEOUT=16 and the controller never acks.
  - Required: `ctrl_req` high for exactly 16 cycles, then one `req_err[owner]` pulse and no `req_ack`. The next pending requester is granted 2 cycles later.
- **Ack/timeout collision**: `ctrl_ack` arrives on the same edge the watchdog expires.
  - Required: `req_ack` pulses and `req_err` stays 0.
- **Reset mid-transaction**: `rst` driven low during GRANT.
  - Required: outputs clear immediately (`ctrl_req`=0, `ctrl_data`=Z) and no ack/err is produced. After release with all four pending, requester 0 is granted first.
